fe_fetch_buf: RTL and testbench

//   Fetch line buffer directly upstream of the fetch controller. It serves one

---
 rtl/fe_fetch_buf_if.sv | 30 +++
 rtl/fe_fetch_buf.sv | 231 +++++++++++++++++++++++
 tb/tb_fe_fetch_buf.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_fetch_buf_if.sv
// Fetch-side and memory-side handshake bundle for the fetch line buffer.
// The slave modport is the buffer; the master modport is its environment.
interface fe_fetch_buf_if #(
  parameter int unsigned PADDR_W    = 32,
  parameter int unsigned LINE_BYTES = 64
);

  logic                    req_valid_nnn;
  logic [PADDR_W-1:0]      req_addr_nnn;
  logic                    rsp_valid_nnn;
  logic [PADDR_W-1:0]      rsp_pc_nnn;
  logic [31:0]             rsp_instr_nnn;
  logic                    flush_rb1;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [PADDR_W-1:0]      mem_req_addr;
  logic                    mem_rsp_valid;
  logic [LINE_BYTES*8-1:0] mem_rsp_data;

  modport master (
    output req_valid_nnn, req_addr_nnn, flush_rb1, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  rsp_valid_nnn, rsp_pc_nnn, rsp_instr_nnn, mem_req_valid, mem_req_addr
  );

  modport slave (
    input  req_valid_nnn, req_addr_nnn, flush_rb1, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output rsp_valid_nnn, rsp_pc_nnn, rsp_instr_nnn, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/fe_fetch_buf.sv
// Fully-associative fetch line buffer: one request at a time, round-robin line fills.
// Define FE_FETCH_BUF_NEXT_LINE_PF_EN to prefetch the next sequential line after a miss.
module fe_fetch_buf #(
  parameter int unsigned PADDR_W    = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned NUM_LINES  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  fe_fetch_buf_if.slave bus,
  output logic          busy
);

  localparam int unsigned OFS_W  = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W  = PADDR_W - OFS_W;
  localparam int unsigned WORDS  = LINE_BYTES / 4;
  localparam int unsigned WORD_W = OFS_W - 2;
  localparam int unsigned VIC_W  = $clog2(NUM_LINES);

  typedef logic [WORDS-1:0][31:0] line_t;
  typedef logic [TAG_W-1:0]       tag_t;

`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
  typedef enum logic [2:0] {
    FbIdle, FbHit, FbMissReq, FbMissWait, FbFillRsp, FbPfReq, FbPfWait
  } state_e;
`else
  typedef enum logic [2:0] {
    FbIdle, FbHit, FbMissReq, FbMissWait, FbFillRsp
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  tag_t                 tag_q [NUM_LINES];
  tag_t                 tag_d [NUM_LINES];
  line_t                data_q [NUM_LINES];
  logic [VIC_W-1:0]     victim_q, victim_d;
  logic                 cancel_q, cancel_d;
  logic [PADDR_W-1:0]   pc_q, pc_d;
  logic                 rsp_q, rsp_d;
  logic [31:0]          instr_q, instr_d;
  logic                 mreq_q, mreq_d;
  tag_t                 mtag_q, mtag_d;
  logic                 busy_q, busy_d;
  logic                 fill_we;

  tag_t                 req_tag;
  logic [WORD_W-1:0]    req_word;
  logic [WORD_W-1:0]    pc_word;
  line_t                fill_line;
  logic                 req_hit;
  logic [VIC_W-1:0]     req_hit_idx;
  logic                 unused_addr;

  assign req_tag     = bus.req_addr_nnn[PADDR_W-1:OFS_W];
  assign req_word    = bus.req_addr_nnn[OFS_W-1:2];
  assign pc_word     = pc_q[OFS_W-1:2];
  assign fill_line   = bus.mem_rsp_data;
  assign unused_addr = ^bus.req_addr_nnn[1:0];

  always_comb begin
    req_hit     = 1'b0;
    req_hit_idx = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        req_hit     = 1'b1;
        req_hit_idx = VIC_W'(i);
      end
    end
  end

`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
  tag_t pf_tag;
  logic pf_hit;

  assign pf_tag = mtag_q + TAG_W'(1);

  always_comb begin
    pf_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == pf_tag)) begin
        pf_hit = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    victim_d = victim_q;
    cancel_d = cancel_q;
    pc_d     = pc_q;
    rsp_d    = 1'b0;
    instr_d  = instr_q;
    mreq_d   = mreq_q;
    mtag_d   = mtag_q;
    fill_we  = 1'b0;

    if ((state_q != FbIdle) && bus.flush_rb1) begin
      cancel_d = 1'b1;
    end

    unique case (state_q)
      FbIdle: begin
        if (bus.req_valid_nnn && !bus.flush_rb1) begin
          pc_d = {bus.req_addr_nnn[PADDR_W-1:2], 2'b00};
          if (req_hit) begin
            instr_d = data_q[req_hit_idx][req_word];
            rsp_d   = 1'b1;
            state_d = FbHit;
          end else begin
            mreq_d  = 1'b1;
            mtag_d  = req_tag;
            state_d = FbMissReq;
          end
        end
      end
      FbHit: begin
        state_d = FbIdle;
      end
      FbMissReq: begin
        if (bus.mem_req_ready) begin
          mreq_d  = 1'b0;
          state_d = FbMissWait;
        end
      end
      FbMissWait: begin
        if (bus.mem_rsp_valid) begin
          fill_we           = 1'b1;
          valid_d[victim_q] = 1'b1;
          tag_d[victim_q]   = mtag_q;
          victim_d          = victim_q + VIC_W'(1);
          instr_d           = fill_line[pc_word];
          rsp_d             = 1'b1;
          state_d           = FbFillRsp;
        end
      end
      FbFillRsp: begin
`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
        if (!pf_hit) begin
          mreq_d  = 1'b1;
          mtag_d  = pf_tag;
          state_d = FbPfReq;
        end else begin
          state_d = FbIdle;
        end
`else
        state_d = FbIdle;
`endif
      end
`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
      FbPfReq: begin
        if (bus.mem_req_ready) begin
          mreq_d  = 1'b0;
          state_d = FbPfWait;
        end
      end
      FbPfWait: begin
        // Prefetch fills the line silently; no response is owed to the fetch side.
        if (bus.mem_rsp_valid) begin
          fill_we           = 1'b1;
          valid_d[victim_q] = 1'b1;
          tag_d[victim_q]   = mtag_q;
          victim_d          = victim_q + VIC_W'(1);
          state_d           = FbIdle;
        end
      end
`endif
      default: begin
        state_d = FbIdle;
      end
    endcase

    if (state_d == FbIdle) begin
      cancel_d = 1'b0;
    end
    busy_d = (state_d != FbIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FbIdle;
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      victim_q <= '0;
      cancel_q <= 1'b0;
      pc_q     <= '0;
      rsp_q    <= 1'b0;
      instr_q  <= '0;
      mreq_q   <= 1'b0;
      mtag_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
      cancel_q <= cancel_d;
      pc_q     <= pc_d;
      rsp_q    <= rsp_d;
      instr_q  <= instr_d;
      mreq_q   <= mreq_d;
      mtag_q   <= mtag_d;
      busy_q   <= busy_d;
    end
  end

  // Line payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[victim_q] <= fill_line;
    end
  end

  // A flush kills the response in the same cycle it is raised.
  assign bus.rsp_valid_nnn = rsp_q & ~cancel_q & ~bus.flush_rb1;
  assign bus.rsp_pc_nnn    = pc_q;
  assign bus.rsp_instr_nnn = instr_q;
  assign bus.mem_req_valid = mreq_q;
  assign bus.mem_req_addr  = {mtag_q, {OFS_W{1'b0}}};
  assign busy              = busy_q;

`ifdef ASSERT_ON
  req_while_busy_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(busy_q && bus.req_valid_nnn));
`endif

endmodule

// File: tb/tb_fe_fetch_buf.sv
// Directed bench for fe_fetch_buf: hits, misses, backpressure, flush, replacement, reset.
// Exercises the next-line prefetch path when FE_FETCH_BUF_NEXT_LINE_PF_EN is defined.
module tb_fe_fetch_buf;

`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
  localparam int MissReqs = 2;
`else
  localparam int MissReqs = 1;
`endif

  logic clk;
  logic reset_n;
  logic busy;

  fe_fetch_buf_if #(.PADDR_W(32), .LINE_BYTES(64)) bus ();

  fe_fetch_buf #(
    .PADDR_W   (32),
    .LINE_BYTES(64),
    .NUM_LINES (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  int          rsp_cnt;
  int          rsp_cyc;
  int          nreq;
  int          vcyc;
  bit          stable;
  bit          done;
  logic [31:0] rsp_instr_s;
  logic [31:0] rsp_pc_s;
  logic [31:0] addr0;
  logic [31:0] addr1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h104) ? 32'h00500093 : (a ^ 32'hC0DE0000);
  endfunction

  function automatic logic [511:0] line_data(input logic [31:0] base);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = mem_word(base + 32'(4 * i));
    return d;
  endfunction

  // One fetch transaction with a simple in-order memory model behind it.
  task automatic run_txn(input logic [31:0] addr, input int ready_delay, input int rsp_delay,
                         input int flush_at);
    int          wait_cnt;
    int          cd;
    bit          pend;
    logic [31:0] acc_addr;
    logic [31:0] first_addr;
    rsp_cnt = 0; rsp_cyc = -1; nreq = 0; vcyc = 0; stable = 1'b1; done = 1'b0;
    addr0 = '0; addr1 = '0; wait_cnt = 0; cd = 0; pend = 1'b0;
    acc_addr = '0; first_addr = '0; rsp_instr_s = '0; rsp_pc_s = '0;
    @(negedge clk);
    bus.req_valid_nnn = 1'b1;
    bus.req_addr_nnn  = addr;
    bus.flush_rb1     = (flush_at == 0);
    for (int c = 1; c <= 80 && !done; c++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end
      bus.req_valid_nnn = 1'b0;
      bus.flush_rb1     = (flush_at == c);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_req_ready = 1'b0;
      if (pend) begin
        if (cd == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = line_data(acc_addr);
          pend = 1'b0;
        end else begin
          cd--;
        end
      end
      if (bus.mem_req_valid) begin
        vcyc++;
        if (wait_cnt == 0) first_addr = bus.mem_req_addr;
        else if (bus.mem_req_addr !== first_addr) stable = 1'b0;
        if (wait_cnt >= ready_delay) begin
          bus.mem_req_ready = 1'b1;
          if (nreq == 0) addr0 = bus.mem_req_addr;
          else addr1 = bus.mem_req_addr;
          nreq++;
          acc_addr = bus.mem_req_addr;
          pend     = 1'b1;
          cd       = rsp_delay;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      #1;
      if (bus.rsp_valid_nnn) begin
        rsp_cnt++;
        if (rsp_cyc < 0) rsp_cyc = c;
        rsp_instr_s = bus.rsp_instr_nnn;
        rsp_pc_s    = bus.rsp_pc_nnn;
      end
    end
    bus.flush_rb1 = 1'b0;
    check_val("txn_done", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b1;
    bus.req_valid_nnn = 1'b0;
    bus.req_addr_nnn  = '0;
    bus.flush_rb1     = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    #1 reset_n = 1'b0;
    #2;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rsp_valid", 32'(bus.rsp_valid_nnn), 32'd0);
    check_val("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_val("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Cold miss then hit in the same line.
    run_txn(32'h100, 0, 0, -1);
    check_val("t1_nreq", 32'(nreq), 32'(MissReqs));
    check_val("t1_fill_addr", addr0, 32'h100);
    check_val("t1_rsp_cnt", 32'(rsp_cnt), 32'd1);
    check_val("t1_fill_instr", rsp_instr_s, 32'hC0DE0100);
    check_val("t1_fill_pc", rsp_pc_s, 32'h100);
    run_txn(32'h104, 0, 0, -1);
    check_val("t1_hit_nreq", 32'(nreq), 32'd0);
    check_val("t1_hit_lat", 32'(rsp_cyc), 32'd1);
    check_val("t1_hit_instr", rsp_instr_s, 32'h00500093);
    check_val("t1_hit_pc", rsp_pc_s, 32'h104);

    // Request coincident with flush is dropped.
    run_txn(32'h108, 0, 0, 0);
    check_val("flushreq_rsp", 32'(rsp_cnt), 32'd0);
    check_val("flushreq_nreq", 32'(nreq), 32'd0);

`ifndef FE_FETCH_BUF_NEXT_LINE_PF_EN
    // Backpressure on the fill request.
    run_txn(32'h180, 5, 0, -1);
    check_val("t2_nreq", 32'(nreq), 32'd1);
    check_val("t2_valid_cycles", 32'(vcyc), 32'd6);
    check_val("t2_stable", 32'(stable), 32'd1);
    check_val("t2_addr", addr0, 32'h180);
    check_val("t2_instr", rsp_instr_s, 32'hC0DE0180);

    // Flush while waiting for fill; fill still lands.
    run_txn(32'h200, 0, 3, 2);
    check_val("t3_rsp_cnt", 32'(rsp_cnt), 32'd0);
    check_val("t3_nreq", 32'(nreq), 32'd1);
    run_txn(32'h204, 0, 0, -1);
    check_val("t3_hit_nreq", 32'(nreq), 32'd0);
    check_val("t3_hit_lat", 32'(rsp_cyc), 32'd1);
    check_val("t3_hit_instr", rsp_instr_s, 32'hC0DE0204);
    run_txn(32'h208, 0, 0, 1);
    check_val("t3_flush_hit", 32'(rsp_cnt), 32'd0);

    // Round-robin replacement over four slots.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn(32'(i * 64), 0, 0, -1);
      check_val("t4_fill_nreq", 32'(nreq), 32'd1);
    end
    run_txn(32'h040, 0, 0, -1);
    check_val("t4_040_nreq", 32'(nreq), 32'd0);
    check_val("t4_040_instr", rsp_instr_s, 32'hC0DE0040);
    run_txn(32'h000, 0, 0, -1);
    check_val("t4_000_nreq", 32'(nreq), 32'd1);
    check_val("t4_000_instr", rsp_instr_s, 32'hC0DE0000);
    run_txn(32'h080, 0, 0, -1);
    check_val("t4_080_nreq", 32'(nreq), 32'd0);
`else
    // Next-line prefetch after a miss.
    do_reset();
    run_txn(32'h300, 0, 0, -1);
    check_val("t6_nreq", 32'(nreq), 32'd2);
    check_val("t6_addr0", addr0, 32'h300);
    check_val("t6_addr1", addr1, 32'h340);
    check_val("t6_rsp_cnt", 32'(rsp_cnt), 32'd1);
    run_txn(32'h340, 0, 0, -1);
    check_val("t6_hit_nreq", 32'(nreq), 32'd0);
    check_val("t6_hit_lat", 32'(rsp_cyc), 32'd1);
    check_val("t6_hit_instr", rsp_instr_s, 32'hC0DE0340);
`endif

    // Async reset while the fill request is pending.
    @(negedge clk);
    bus.req_valid_nnn = 1'b1;
    bus.req_addr_nnn  = 32'h3C0;
    @(negedge clk);
    bus.req_valid_nnn = 1'b0;
    check_val("t5_in_req", 32'(bus.mem_req_valid), 32'd1);
    check_val("t5_req_addr", bus.mem_req_addr, 32'h3C0);
    #2 reset_n = 1'b0;
    #1;
    check_val("t5_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_val("t5_rst_req_addr", bus.mem_req_addr, 32'h0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_pc", bus.rsp_pc_nnn, 32'h0);
    check_val("t5_rst_instr", bus.rsp_instr_nnn, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = line_data(32'h3C0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    check_val("t5_late_rsp_busy", 32'(busy), 32'd0);
    #1;
    check_val("t5_late_rsp_valid", 32'(bus.rsp_valid_nnn), 32'd0);
    run_txn(32'h100, 0, 0, -1);
    check_val("t5_post_nreq", 32'(nreq), 32'(MissReqs));
    check_val("t5_post_addr", addr0, 32'h100);
    check_val("t5_post_instr", rsp_instr_s, 32'hC0DE0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
